// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Serves CPU loads/stores from a line array and acts as the initiator toward a
// blocking line-based memory (64-bit lines of four 16-bit words). On a miss the
// victim line is written back first if dirty, then the requested line is filled
// and the request completes as a hit. Hit and miss counters are provided.
module dcache_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int WORD_SIZE = 16,
  parameter int LINE_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [WORD_SIZE-1:0] cpu_address,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_done,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  inout  wire  [LINE_SIZE-1:0] mem_data,
  input  logic                 mem_readyM,
  input  logic                 mem_input_readyM,
  input  logic                 mem_doneM,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = WORD_SIZE - INDEX_BITS - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_WAIT,
    S_FILL_REQ,
    S_FILL_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  // Per-line bookkeeping and storage.
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
  logic [LINE_SIZE-1:0] r_data [NUM_LINES];

  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  // Address decomposition of the current CPU request.
  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_req;
  logic                  w_hit;
  logic [LINE_SIZE-1:0]  w_line;
  logic [WORD_SIZE-1:0]  w_word;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_write_hit;
  logic                  w_fill;

  assign w_offset = cpu_address[1:0];
  assign w_index  = cpu_address[INDEX_BITS+1:2];
  assign w_tag    = cpu_address[WORD_SIZE-1:INDEX_BITS+2];
  // A simultaneous read and write is handled as a write.
  assign w_req    = cpu_read | cpu_write;
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line   = r_data[w_index];
  assign w_word   = w_line[w_offset*WORD_SIZE +: WORD_SIZE];

  assign w_write_hit = (r_state == S_IDLE) && w_req && w_hit && cpu_write;
  assign w_fill      = (r_state == S_FILL_WAIT) && mem_input_readyM;

  // The line bus is only driven while a write-back request is on it.
  assign mem_data = mem_writeM ? w_line : {LINE_SIZE{1'bz}};

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // State register plus valid/dirty bookkeeping.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_write_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
        r_dirty[w_index] <= 1'b0;
      end
    end
  end

  // Line data and tag storage: fills replace a line, write hits merge one word.
  // NOTE: the storage arrays have no reset; valid bits alone decide whether
  // their contents mean anything, and a reset-free array maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_index] <= mem_data;
      r_tag[w_index]  <= w_tag;
    end else if (w_write_hit) begin
      r_data[w_index][w_offset*WORD_SIZE +: WORD_SIZE] <= cpu_wdata;
    end
  end

  // Performance counters; they wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_inc) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_miss_inc) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  // Next-state and output decode; memory requests are held only in *_REQ
  // states, which are left at the first accepting edge.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_next      = r_state;
    cpu_done    = 1'b0;
    cpu_rdata   = '0;
    mem_readM   = 1'b0;
    mem_writeM  = 1'b0;
    mem_address = '0;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            cpu_done  = 1'b1;
            cpu_rdata = w_word;
            w_hit_inc = 1'b1;
          end else begin
            w_miss_inc = 1'b1;
            if (r_valid[w_index] && r_dirty[w_index]) begin
              w_next = S_WB_REQ;
            end else begin
              w_next = S_FILL_REQ;
            end
          end
        end
      end
      S_WB_REQ: begin
        mem_writeM  = 1'b1;
        mem_address = {r_tag[w_index], w_index, 2'b00};
        if (mem_readyM) begin
          w_next = S_WB_WAIT;
        end
      end
      S_WB_WAIT: begin
        if (mem_doneM) begin
          w_next = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        mem_readM   = 1'b1;
        mem_address = {w_tag, w_index, 2'b00};
        if (mem_readyM) begin
          w_next = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if (mem_input_readyM) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a 6-cycle blocking line
// memory, a flat reference memory plus tag-store model predicting data,
// latency category and bus traffic, and one per-cycle compare process.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_address = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        mem_readM;
  logic        mem_writeM;
  logic [15:0] mem_address;
  wire  [63:0] mem_data;
  logic        mem_readyM;
  logic        mem_input_readyM;
  logic        mem_doneM;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dcache_ctrl #(.NUM_LINES(16), .WORD_SIZE(16), .LINE_SIZE(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_readyM(mem_readyM), .mem_input_readyM(mem_input_readyM),
    .mem_doneM(mem_doneM),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial memory image shared by the bus memory and the reference memory.
  function automatic logic [15:0] init_val(input int a);
    case (a)
      'h00: return 16'h9023;
      'h01: return 16'h1111;
      'h02: return 16'hFFFF;
      'h03: return 16'h0000;
      'h20, 'h21, 'h22: return 16'h0000;
      'h23: return 16'h6000;
      'h41: return 16'hF9C1;
      default: return 16'(a * 257) ^ 16'h5A5A;
    endcase
  endfunction

  // ---------------- bus memory: 6-cycle blocking line memory ----------------
  logic [15:0] bmem [256];
  int          m_cnt = 0;
  logic        m_is_rd = 1'b0;
  logic [7:0]  m_base = '0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [15:0] last_wb_addr = '0;
  logic [63:0] last_wb_data = '0;

  assign mem_readyM       = (m_cnt == 0);
  assign mem_doneM        = (m_cnt == 1);
  assign mem_input_readyM = (m_cnt == 1) && m_is_rd;
  assign mem_data = mem_input_readyM ?
      {bmem[m_base + 8'd3], bmem[m_base + 8'd2], bmem[m_base + 8'd1], bmem[m_base]} : 64'bz;

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
      end else if (mem_readM || mem_writeM) begin
        m_cnt   <= 6;
        m_is_rd <= mem_readM;
        m_base  <= {mem_address[7:2], 2'b00};
        if (mem_writeM) begin
          for (int w = 0; w < 4; w++)
            bmem[{mem_address[7:2], 2'b00} + 8'(w)] <= mem_data[16*w +: 16];
          n_wr         <= n_wr + 1;
          last_wb_addr <= mem_address;
          last_wb_data <= mem_data;
        end else begin
          n_rd <= n_rd + 1;
        end
      end
    end
  end

  // ---------------- reference model (driver-owned) ----------------
  logic [15:0] ref_mem [256];
  logic [15:0] m_valid = '0;
  logic [15:0] m_dirty = '0;
  logic [9:0]  m_tag [16];

  logic        active = 1'b0;
  int          req_id = 0;
  int          exp_lat = 0;
  logic        exp_dirty = 1'b0;
  logic        exp_is_read = 1'b0;
  logic [15:0] exp_rdata = '0;
  logic [15:0] exp_fill_addr = '0;
  logic [15:0] exp_wb_addr = '0;
  logic [63:0] exp_wb_data = '0;

  // Predict the outcome of one request from the architectural view, then
  // update that view as the request would leave it.
  task automatic model_start(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] wd);
    logic [3:0] idx;
    logic [9:0] tg;
    logic [7:0] vb;
    idx = a[5:2];
    tg  = a[15:6];
    exp_is_read   = rd && !wr;
    exp_rdata     = ref_mem[a[7:0]];
    exp_fill_addr = {a[15:2], 2'b00};
    exp_dirty     = 1'b0;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      exp_lat = 0;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_dirty   = 1'b1;
        exp_lat     = 15;
        exp_wb_addr = {m_tag[idx], idx, 2'b00};
        vb          = exp_wb_addr[7:0];
        exp_wb_data = {ref_mem[vb + 8'd3], ref_mem[vb + 8'd2], ref_mem[vb + 8'd1], ref_mem[vb]};
      end else begin
        exp_lat = 8;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_mem[a[7:0]] = wd;
      m_dirty[idx]    = 1'b1;
    end
  endtask

  // ---------------- compare process (checker-owned state) ----------------
  int          k = 0;
  int          seen_id = 0;
  logic        fin = 1'b0;
  int          done_events = 0;
  int          last_lat = -1;
  logic [15:0] last_rdata = '0;
  logic [15:0] exp_hit = '0;
  logic [15:0] exp_miss = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_hit  = '0;
      exp_miss = '0;
    end else begin
      check("hit_count", 64'(hit_count), 64'(exp_hit));
      check("miss_count", 64'(miss_count), 64'(exp_miss));
      if (active) begin
        if (req_id != seen_id) begin
          seen_id = req_id;
          k       = 0;
          fin     = 1'b0;
        end
        if (!fin) begin
          logic exp_w, exp_r;
          exp_w = exp_dirty && (k == 1);
          exp_r = (exp_lat != 0) && (k == (exp_dirty ? 8 : 1));
          check("cpu_done", 64'(cpu_done), 64'(k == exp_lat));
          check("mem_writeM", 64'(mem_writeM), 64'(exp_w));
          check("mem_readM", 64'(mem_readM), 64'(exp_r));
          if (exp_w) begin
            check("wb_address", 64'(mem_address), 64'(exp_wb_addr));
            check("wb_data", mem_data, exp_wb_data);
          end
          if (exp_r) check("fill_address", 64'(mem_address), 64'(exp_fill_addr));
          if (k == 0 && exp_lat != 0) exp_miss = exp_miss + 16'd1;
          if (k == exp_lat) exp_hit = exp_hit + 16'd1;
          if (cpu_done) begin
            if (exp_is_read) check("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
            fin         = 1'b1;
            done_events = done_events + 1;
            last_lat    = k;
            last_rdata  = cpu_rdata;
          end
          k = k + 1;
        end
      end else begin
        check("idle_mem_readM", 64'(mem_readM), 64'd0);
        check("idle_mem_writeM", 64'(mem_writeM), 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic launch(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd);
    model_start(rd, wr, a, wd);
    cpu_read    = rd;
    cpu_write   = wr;
    cpu_address = a;
    cpu_wdata   = wd;
    req_id      = req_id + 1;
    active      = 1'b1;
  endtask

  // Issue one request (called #1 after an edge) and hold it until the edge
  // that closes cpu_done; returns #1 after that edge.
  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, input string name);
    int start;
    start = done_events;
    launch(rd, wr, a, wd);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      if (done_events != start) break;
    end
    check({name, "_completed"}, 64'(done_events - start), 64'd1);
    #1;
    active    = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 16; i++) m_tag[i] = '0;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_cpu_done", 64'(cpu_done), 64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_mem_readM", 64'(mem_readM), 64'd0);
    check("rst_mem_writeM", 64'(mem_writeM), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    @(posedge clk);
    #1;

    // Clean miss, then fill re-hit.
    req(1'b1, 1'b0, 16'h0023, 16'h0000, "rd_0023");
    check("rd_0023_rdata", 64'(last_rdata), 64'h6000);
    check("rd_0023_latency", 64'(last_lat), 64'd8);
    check("rd_0023_misses", 64'(miss_count), 64'd1);
    check("rd_0023_reads", 64'(n_rd), 64'd1);

    // Back-to-back hit in the same line.
    req(1'b1, 1'b0, 16'h0021, 16'h0000, "rd_0021");
    check("rd_0021_rdata", 64'(last_rdata), 64'h0000);
    check("rd_0021_latency", 64'(last_lat), 64'd0);
    check("rd_0021_hits", 64'(hit_count), 64'd2);
    check("rd_0021_reads", 64'(n_rd), 64'd1);

    // Write miss allocates line 0x0000, then merges.
    req(1'b0, 1'b1, 16'h0001, 16'hBEEF, "wr_0001");
    check("wr_0001_latency", 64'(last_lat), 64'd8);
    req(1'b1, 1'b0, 16'h0001, 16'h0000, "rd_0001");
    check("rd_0001_rdata", 64'(last_rdata), 64'hBEEF);
    check("rd_0001_latency", 64'(last_lat), 64'd0);
    check("rd_0001_reads", 64'(n_rd), 64'd2);

    // Conflict miss on a dirty line: write-back then fill.
    req(1'b1, 1'b0, 16'h0041, 16'h0000, "rd_0041");
    check("rd_0041_rdata", 64'(last_rdata), 64'hF9C1);
    check("rd_0041_latency", 64'(last_lat), 64'd15);
    check("rd_0041_wb_addr", 64'(last_wb_addr), 64'h0000);
    check("rd_0041_wb_data", last_wb_data, 64'h0000_FFFF_BEEF_9023);
    check("rd_0041_writes", 64'(n_wr), 64'd1);

    // The write-back reached memory.
    req(1'b1, 1'b0, 16'h0001, 16'h0000, "rerd_0001");
    check("rerd_0001_rdata", 64'(last_rdata), 64'hBEEF);
    check("rerd_0001_latency", 64'(last_lat), 64'd8);
    check("rerd_0001_hits", 64'(hit_count), 64'd6);
    check("rerd_0001_misses", 64'(miss_count), 64'd4);

    // Reset during FILL_WAIT aborts the fill.
    launch(1'b1, 1'b0, 16'h0083, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    reset_n   = 1'b0;
    active    = 1'b0;
    cpu_read  = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_valid = '0;
    m_dirty = '0;
    @(negedge clk);
    check("abort_mem_readM", 64'(mem_readM), 64'd0);
    check("abort_mem_writeM", 64'(mem_writeM), 64'd0);
    check("abort_mem_address", 64'(mem_address), 64'd0);
    check("abort_hits", 64'(hit_count), 64'd0);
    check("abort_misses", 64'(miss_count), 64'd0);
    check("abort_cpu_rdata", 64'(cpu_rdata), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_mem_idle", 64'(mem_readyM), 64'd1);

    req(1'b1, 1'b0, 16'h0083, 16'h0000, "rd_0083");
    check("rd_0083_latency", 64'(last_lat), 64'd8);

    // Read and write together behave as a write.
    req(1'b1, 1'b1, 16'h0082, 16'h1234, "rw_0082");
    check("rw_0082_latency", 64'(last_lat), 64'd0);
    req(1'b1, 1'b0, 16'h0082, 16'h0000, "rd_0082");
    check("rd_0082_rdata", 64'(last_rdata), 64'h1234);
    check("rd_0082_hits", 64'(hit_count), 64'd3);
    check("rd_0082_misses", 64'(miss_count), 64'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the CPU data port and the line-based data port of the latency-modelled memory (64-bit line = 4 x 16-bit words, 6-cycle blocking operation).
- Acts as the initiator of that memory protocol: issues one-cycle line read/write requests, waits for done/input-ready, and fills or evicts lines.
- Also keeps hit/miss performance counters.

Parameters:
- NUM_LINES, 16, number of cache lines; power of 2, >=2; INDEX_BITS = log2(NUM_LINES).
- WORD_SIZE, 16, CPU word and address width.
- LINE_SIZE, 64, line width = 4*WORD_SIZE; fixed.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- cpu_read  in  1  load request; held stable until cpu_done.
- cpu_write  in  1  store request; held stable until cpu_done.
- cpu_address  in  16  word address.
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid while cpu_done=1.
- cpu_done  out  1  request completes this cycle.
- mem_readM  out  1  line read request.
- mem_writeM  out  1  line write request.
- mem_address  out  16  line address, low 2 bits always 00.
- mem_data  inout  64  driven by this block only while mem_writeM=1, else high-Z.
- mem_readyM  in  1  memory idle; request accepted at a rising edge when high.
- mem_input_readyM  in  1  one-cycle pulse; mem_data holds the read line.
- mem_doneM  in  1  one-cycle pulse at the end of any memory operation.
- hit_count  out  16  completed hits.
- miss_count  out  16  misses.

Clock and reset: clk is the clock; reset_n is a synchronous, active-low reset.

Behaviour:
- Address split:
  - offset = addr[1:0]; word k occupies line bits [16k+15:16k].
  - index = addr[INDEX_BITS+1:2]; tag = addr[15:INDEX_BITS+2].
- Per line state: valid, dirty, tag, 64-bit data. Data array is not reset.
- Reset:
  - state=IDLE; all valid and dirty cleared.
  - mem_readM=mem_writeM=0; mem_address=0; mem_data=Z.
  - cpu_done=0; cpu_rdata=0; hit_count=miss_count=0.
  - Reset mid-operation aborts any transfer; the outstanding line is discarded.
- Request and hit:
  - req = cpu_read|cpu_write; if both are high, treat as write.
  - hit = valid[index] & tag match.
- IDLE state:
  - req & hit: cpu_done=1 combinationally in the same cycle; cpu_rdata = selected word combinationally.
  - Write hit: word updated and dirty set at the closing edge.
  - Every cycle with req & hit increments hit_count at the edge.
  - req & miss: miss_count+1 (once per miss); next state WB_REQ if victim valid&dirty, else FILL_REQ; cpu_done=0.
- WB_REQ:
  - mem_writeM=1; mem_address={victim_tag,index,00}; mem_data=victim line.
  - Leave to WB_WAIT at the first edge with mem_readyM=1, then drop mem_writeM.
- WB_WAIT:
  - No request asserted; wait for mem_doneM=1, then go to FILL_REQ.
- FILL_REQ:
  - mem_readM=1; mem_address={cpu_tag,index,00}.
  - Leave to FILL_WAIT at the first edge with mem_readyM=1.
- FILL_WAIT:
  - On mem_input_readyM=1, latch mem_data into the line at that edge; set valid, tag; clear dirty; go to IDLE.
  - The request then hits in IDLE. A write then merges and sets dirty.
- Memory requests are asserted for exactly one accepted cycle. Holding one longer would be re-accepted by memory and is a bug.
- Counters wrap at 16'hFFFF -> 0.
- CPU changing address or type before cpu_done is illegal; behaviour is undefined.
- Latency, in cycles from first request cycle 0 to cpu_done, with 6-cycle memory:
  - hit: 0.
  - clean miss: 8.
  - dirty miss: 15.

Test Plan:
- Reset, then read 0x0023 (memory 0x0020..0x0023 = 0,0,0,0x6000) -> mem_readM pulse once with mem_address=0x0020; cpu_done in cycle 8 with cpu_rdata=0x6000; miss_count=1.
- Back-to-back read 0x0021 after the previous scenario -> cpu_done same cycle, cpu_rdata=0x0000, no memory request; hit_count=2 (the fill re-hit plus this one).
- Write 0x0001 data 0xBEEF (miss, clean) -> fill of line 0x0000, then write-hit; subsequent read 0x0001 returns 0xBEEF with zero latency and no memory traffic.
- With NUM_LINES=16, read 0x0041 (same index 0, other tag) after the dirty line 0x0000 -> mem_writeM pulse at 0x0000 with mem_data={0xffff→word2,0xBEEF→word1,0x9023→word0,word3=0}, i.e. 64'h0000_FFFF_BEEF_9023; after mem_doneM, mem_readM at 0x0040; cpu_done in cycle 15 with rdata=0xf9c1 (memory word 0x41).
- Re-read 0x0001 -> clean miss that returns 0xBEEF, proving the write-back reached memory.
- Assert reset_n=0 one cycle while in FILL_WAIT -> next cycle IDLE, mem requests 0, counters 0; subsequent read to the same address misses again.
